// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI mode-0 responder
package spi_pkg;
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;
  localparam int SYNC_STAGES = 2;
  localparam logic [7:0] DEFAULT_DUMMY = 8'hFF;
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: two-flop synchroniser with level, rise and fall outputs
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk)
    if (rst) begin
      sync <= {SYNC_STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      prev <= sync[SYNC_STAGES-1];
    end
  assign level = sync[SYNC_STAGES-1];
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI mode-0 target with byte RX strobe and one-deep TX holding register
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int N = 5,
  parameter logic [7:0] DUMMY = DEFAULT_DUMMY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         spi_sclk_i,
  input  logic         spi_cs_n_i,
  input  logic         spi_mosi_i,
  output logic         spi_miso_o,
  output logic         miso_oe_o,
  input  logic [7:0]   tx_data_i,
  input  logic         tx_valid_i,
  output logic         tx_ready_o,
  output logic         tx_underrun_o,
  output logic [7:0]   rx_byte_o,
  output logic         rx_dv_o,
  output logic         cs_abort_o,
  output logic         busy_o,
  output logic [N:0]   byte_cnt_o
);
  localparam logic [1:0] SETTLE = 2'(SYNC_STAGES);
  state_t state, state_nxt;
  logic sclk_unused, sclk_rise, sclk_fall, cs_n, cs_rise, cs_fall, mosi;
  logic [1:0] mosi_unused, settle;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sh, rx_sh, hold;
  logic hold_full, start, stop, sample, drive, load;
  spi_sync_edge #(.RST_VAL(SPI_CPOL)) u_sclk (.clk(clk), .rst(rst), .d(spi_sclk_i), .level(sclk_unused), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (.clk(clk), .rst(rst), .d(spi_cs_n_i), .level(cs_n), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .rst(rst), .d(spi_mosi_i), .level(mosi), .rise(mosi_unused[0]), .fall(mosi_unused[1]));
  always_ff @(posedge clk)
    if (rst) begin
      state <= WAIT_IDLE;
      settle <= '0;
    end else begin
      state <= state_nxt;
      settle <= settle == SETTLE ? settle : settle + 2'd1;
    end
  always_comb
    state_nxt = state == WAIT_IDLE ? (cs_n && settle == SETTLE ? IDLE : WAIT_IDLE)
              : state == IDLE ? (cs_fall ? SHIFT : IDLE)
              : (cs_rise ? IDLE : SHIFT);
  always_comb begin
    start = state == IDLE && cs_fall;
    stop = state == SHIFT && cs_rise;
    sample = state == SHIFT && !cs_rise && ((SPI_CPOL ^ SPI_CPHA) ? sclk_fall : sclk_rise);
    drive = state == SHIFT && !cs_rise && ((SPI_CPOL ^ SPI_CPHA) ? sclk_rise : sclk_fall);
    load = start || (drive && bit_cnt == 3'd0);
  end
  assign tx_ready_o = !hold_full;
  always_ff @(posedge clk)
    if (rst) begin
      hold_full <= 1'b0;
      hold <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      bit_cnt <= '0;
      spi_miso_o <= 1'b0;
      miso_oe_o <= 1'b0;
      tx_underrun_o <= 1'b0;
      rx_byte_o <= '0;
      rx_dv_o <= 1'b0;
      cs_abort_o <= 1'b0;
      busy_o <= 1'b0;
      byte_cnt_o <= '0;
    end else begin
      tx_underrun_o <= load && !hold_full;
      rx_dv_o <= sample && bit_cnt == 3'd7;
      cs_abort_o <= stop && bit_cnt != 3'd0;
      if (tx_valid_i && !hold_full) begin
        hold <= tx_data_i;
        hold_full <= 1'b1;
      end else if (load)
        hold_full <= 1'b0;
      if (load) begin
        tx_sh <= hold_full ? hold : DUMMY;
        spi_miso_o <= hold_full ? hold[7] : DUMMY[7];
      end else if (drive) begin
        tx_sh <= tx_sh << 1;
        spi_miso_o <= tx_sh[6];
      end else if (stop)
        spi_miso_o <= 1'b0;
      if (start) begin
        miso_oe_o <= 1'b1;
        busy_o <= 1'b1;
        byte_cnt_o <= '0;
        bit_cnt <= '0;
      end else if (stop) begin
        miso_oe_o <= 1'b0;
        busy_o <= 1'b0;
        bit_cnt <= '0;
      end else if (sample) begin
        rx_sh <= {rx_sh[6:0], mosi};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte_o <= {rx_sh[6:0], mosi};
          byte_cnt_o <= &byte_cnt_o ? byte_cnt_o : byte_cnt_o + (N+1)'(1);
        end
      end
    end
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: randomized SPI master against a transaction-level TX/RX model
module tb_spi_slave_responder;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b0, mosi = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic spi_miso_o, miso_oe_o, tx_ready_o, tx_underrun_o, rx_dv_o, cs_abort_o, busy_o;
  logic [7:0] rx_byte_o;
  logic [5:0] byte_cnt_o;
  int n_checks = 0, n_fail = 0;
  int dv_cnt = 0, und_cnt = 0, abort_cnt = 0, und_exp = 0;
  logic oe_seen = 1'b0;
  logic [7:0] rx_got[$];
  logic [7:0] hold_q[$];
  logic [7:0] cur_tx = 8'h00;

  spi_slave_responder #(.N(5), .DUMMY(8'hFF)) dut (
    .clk(clk), .rst(rst), .spi_sclk_i(sclk), .spi_cs_n_i(cs_n), .spi_mosi_i(mosi),
    .spi_miso_o(spi_miso_o), .miso_oe_o(miso_oe_o), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready_o), .tx_underrun_o(tx_underrun_o), .rx_byte_o(rx_byte_o), .rx_dv_o(rx_dv_o),
    .cs_abort_o(cs_abort_o), .busy_o(busy_o), .byte_cnt_o(byte_cnt_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_dv_o === 1'b1) begin
      dv_cnt++;
      rx_got.push_back(rx_byte_o);
    end
    if (tx_underrun_o === 1'b1) und_cnt++;
    if (cs_abort_o === 1'b1) abort_cnt++;
    if (miso_oe_o === 1'b1) oe_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_load();
    if (hold_q.size() > 0) cur_tx = hold_q.pop_front();
    else begin
      cur_tx = 8'hFF;
      und_exp++;
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    int t = 0;
    while (tx_ready_o !== 1'b1 && t < 50) begin
      tick(1);
      t++;
    end
    n_checks++;
    if (tx_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL push_ready_timeout: tx_ready_o=%b, expected 1", tx_ready_o);
    end
    tx_data = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    hold_q.push_back(b);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(5);
    model_load();
  endtask

  task automatic cs_high();
    tick(2);
    cs_n = 1'b1;
    tick(6);
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nb, input bit do_push, input logic [7:0] pb, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      mosi = mo[i];
      tick(4);
      mi[i] = spi_miso_o;
      sclk = 1'b1;
      tick(1);
      if (do_push && i == 7) push_tx(pb);
      tick(3);
      sclk = 1'b0;
    end
    if (nb == 8) model_load();
  endtask

  task automatic xfer_byte(input logic [7:0] mo, input bit do_push, input logic [7:0] pb);
    logic [7:0] exp_tx, mi;
    exp_tx = cur_tx;
    rx_got.delete();
    spi_bits(mo, 8, do_push, pb, mi);
    n_checks++;
    if (mi !== exp_tx) begin
      n_fail++;
      $display("FAIL miso_byte: got %h, expected %h", mi, exp_tx);
    end
    n_checks++;
    if (rx_got.size() != 1 || rx_got[0] !== mo) begin
      n_fail++;
      $display("FAIL rx_byte: got %0d strobes (first %h), expected one strobe of %h", rx_got.size(), rx_got.size() > 0 ? rx_got[0] : 8'hxx, mo);
    end
  endtask

  task automatic test_reset();
    logic [7:0] mi;
    cs_n = 1'b0;
    rst = 1'b1;
    tick(3);
    n_checks++;
    if ({spi_miso_o, miso_oe_o, tx_ready_o, tx_underrun_o, rx_dv_o, cs_abort_o, busy_o} !== 7'b0010000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 0010000", {spi_miso_o, miso_oe_o, tx_ready_o, tx_underrun_o, rx_dv_o, cs_abort_o, busy_o});
    end
    n_checks++;
    if (rx_byte_o !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rx_byte: got %h, expected 00", rx_byte_o);
    end
    n_checks++;
    if (byte_cnt_o !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_byte_cnt: got %0d, expected 0", byte_cnt_o);
    end
    rst = 1'b0;
    hold_q.delete();
    dv_cnt = 0;
    und_cnt = 0;
    und_exp = 0;
    oe_seen = 1'b0;
    spi_bits(8'($urandom), 8, 1'b0, 8'h00, mi);
    tick(4);
    n_checks++;
    if (dv_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_cs_low_rx_dv: got %0d strobes, expected 0", dv_cnt);
    end
    n_checks++;
    if (oe_seen !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cs_low_oe: oe_seen=%b busy=%b, expected 0 0", oe_seen, busy_o);
    end
    n_checks++;
    if (und_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_cs_low_underrun: got %0d, expected 0", und_cnt);
    end
    cs_n = 1'b1;
    tick(6);
  endtask

  task automatic test_single();
    und_cnt = 0;
    und_exp = 0;
    dv_cnt = 0;
    push_tx(8'hA5);
    n_checks++;
    if (tx_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_held_ready: got %b, expected 0", tx_ready_o);
    end
    cs_low();
    n_checks++;
    if (busy_o !== 1'b1 || miso_oe_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_start: busy=%b oe=%b, expected 1 1", busy_o, miso_oe_o);
    end
    xfer_byte(8'h3C, 1'b0, 8'h00);
    cs_high();
    n_checks++;
    if (dv_cnt !== 1 || byte_cnt_o !== 6'd1) begin
      n_fail++;
      $display("FAIL single_counts: dv=%0d byte_cnt=%0d, expected 1 1", dv_cnt, byte_cnt_o);
    end
    n_checks++;
    if (busy_o !== 1'b0 || miso_oe_o !== 1'b0 || spi_miso_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: busy=%b oe=%b miso=%b, expected 0 0 0", busy_o, miso_oe_o, spi_miso_o);
    end
    n_checks++;
    if (und_cnt !== und_exp) begin
      n_fail++;
      $display("FAIL single_underrun: got %0d, expected %0d", und_cnt, und_exp);
    end
  endtask

  task automatic test_burst();
    und_cnt = 0;
    und_exp = 0;
    dv_cnt = 0;
    push_tx(8'hA5);
    cs_low();
    xfer_byte(8'h01, 1'b1, 8'h5A);
    xfer_byte(8'h02, 1'b1, 8'hC3);
    xfer_byte(8'h03, 1'b1, 8'h77);
    cs_high();
    n_checks++;
    if (dv_cnt !== 3 || byte_cnt_o !== 6'd3) begin
      n_fail++;
      $display("FAIL burst_counts: dv=%0d byte_cnt=%0d, expected 3 3", dv_cnt, byte_cnt_o);
    end
    n_checks++;
    if (und_cnt !== und_exp) begin
      n_fail++;
      $display("FAIL burst_underrun: got %0d, expected %0d", und_cnt, und_exp);
    end
  endtask

  task automatic test_underrun();
    und_cnt = 0;
    und_exp = 0;
    push_tx(8'h11);
    cs_low();
    xfer_byte(8'hAA, 1'b0, 8'h00);
    xfer_byte(8'h55, 1'b1, 8'h22);
    cs_high();
    n_checks++;
    if (und_cnt !== und_exp) begin
      n_fail++;
      $display("FAIL underrun_count: got %0d, expected %0d", und_cnt, und_exp);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx_before, mi;
    und_cnt = 0;
    und_exp = 0;
    dv_cnt = 0;
    abort_cnt = 0;
    rx_before = rx_byte_o;
    cs_low();
    spi_bits(8'($urandom), 5, 1'b0, 8'h00, mi);
    cs_high();
    n_checks++;
    if (abort_cnt !== 1 || dv_cnt !== 0) begin
      n_fail++;
      $display("FAIL abort_pulses: abort=%0d dv=%0d, expected 1 0", abort_cnt, dv_cnt);
    end
    n_checks++;
    if (busy_o !== 1'b0 || rx_byte_o !== rx_before || byte_cnt_o !== 6'd0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b rx=%h byte_cnt=%0d, expected 0 %h 0", busy_o, rx_byte_o, byte_cnt_o, rx_before);
    end
    n_checks++;
    if (und_cnt !== und_exp) begin
      n_fail++;
      $display("FAIL abort_underrun: got %0d, expected %0d", und_cnt, und_exp);
    end
  endtask

  task automatic test_same_cycle_load();
    int t = 0;
    und_cnt = 0;
    und_exp = 0;
    push_tx(8'hA5);
    cs_n = 1'b0;
    tick(2);
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    model_load();
    hold_q.push_back(8'h5A);
    while (tx_ready_o !== 1'b1 && t < 20) begin
      tick(1);
      t++;
    end
    tick(1);
    tx_valid = 1'b0;
    n_checks++;
    if (tx_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_held: tx_ready_o=%b, expected 0", tx_ready_o);
    end
    tick(2);
    xfer_byte(8'h96, 1'b0, 8'h00);
    n_checks++;
    if (tx_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_ready_mid: tx_ready_o=%b, expected 0", tx_ready_o);
    end
    tick(4);
    n_checks++;
    if (tx_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_ready_after: tx_ready_o=%b, expected 1", tx_ready_o);
    end
    xfer_byte(8'h69, 1'b0, 8'h00);
    cs_high();
    n_checks++;
    if (und_cnt !== und_exp) begin
      n_fail++;
      $display("FAIL same_cycle_underrun: got %0d, expected %0d", und_cnt, und_exp);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int nb;
      und_cnt = 0;
      und_exp = 0;
      nb = int'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1 && hold_q.size() == 0) push_tx(8'($urandom));
      cs_low();
      for (int b = 0; b < nb; b++) xfer_byte(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      cs_high();
      n_checks++;
      if (byte_cnt_o !== 6'(nb)) begin
        n_fail++;
        $display("FAIL random_byte_cnt: got %0d, expected %0d", byte_cnt_o, nb);
      end
      n_checks++;
      if (und_cnt !== und_exp) begin
        n_fail++;
        $display("FAIL random_underrun: got %0d, expected %0d", und_cnt, und_exp);
      end
    end
  endtask

  task automatic test_saturate();
    int nb = 66;
    cs_low();
    for (int b = 0; b < nb; b++) xfer_byte(8'($urandom), 1'b0, 8'h00);
    cs_high();
    n_checks++;
    if (byte_cnt_o !== 6'(nb > 63 ? 63 : nb)) begin
      n_fail++;
      $display("FAIL saturate_byte_cnt: got %0d, expected %0d", byte_cnt_o, nb > 63 ? 63 : nb);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_underrun();
    test_abort();
    test_same_cycle_load();
    test_random();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
